// File: rtl/bus_arbiter_if.sv
// Read/write bus bundle shared by the two masters and the downstream slave.
//   ar : read address  (arvalid/arready/araddr)
//   r  : read data     (rvalid/rready/rdata/rresp)
//   aw : write address (awvalid/awready/awaddr)
//   w  : write data    (wvalid/wready/wdata/wstrb)
//   b  : write resp    (bvalid/bready/bresp)
// master modport: the side that issues requests; slave modport: the side that answers.
interface bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              arvalid, arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid, rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              awvalid, awready;
  logic [ADDR_W-1:0] awaddr;
  logic              wvalid, wready;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic              bvalid, bready;
  logic [1:0]        bresp;

  modport master (
    output arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
    input  arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
  );
  modport slave (
    input  arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
    output arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master, single-outstanding bus arbiter.
//   clk, rst : clock, synchronous active-high reset
//   m0       : instruction-fetch master (read channels only; write outputs tied 0)
//   m1       : load/store master (read and write channels)
//   s        : downstream slave port
// Masters alternate round-robin on a tie; within m1 a write beats a read.
// The grant is registered; once granted, a transaction runs to its r/b
// handshake before the arbiter returns to IDLE for exactly one cycle.
module bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  bus_arbiter_if.slave  m0,
  bus_arbiter_if.slave  m1,
  bus_arbiter_if.master s
);
  typedef enum logic [1:0] {IDLE, RD0, RD1, WR1} state_e;

  state_e state_q, state_d, st;
  logic   last_q, last_d;           // 0 = m0 granted last, 1 = m1
  logic   ar_done_q, ar_done_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;

  logic req0, req1, wr1_req, pick1;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] wr_data;

  assign req0    = m0.arvalid;
  assign wr1_req = m1.awvalid | m1.wvalid;
  assign req1    = m1.arvalid | wr1_req;
  // m1 wins when alone, or on a tie when m0 was served last
  assign pick1   = req1 & (~req0 | ~last_q);

  // Outputs are decoded from IDLE while reset is held, so an abandoned
  // transaction drops its handshakes in the reset cycle itself.
  assign st = rst ? IDLE : state_q;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    ar_done_d = ar_done_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          last_d  = pick1;
          state_d = !pick1 ? RD0 : (wr1_req ? WR1 : RD1);
        end
      end
      RD0, RD1: begin
        if (s.arvalid && s.arready) ar_done_d = 1'b1;
        if (s.rvalid && s.rready) begin
          state_d   = IDLE;
          ar_done_d = 1'b0;
        end
      end
      WR1: begin
        if (s.awvalid && s.awready) aw_done_d = 1'b1;
        if (s.wvalid && s.wready)   w_done_d  = 1'b1;
        if (s.bvalid && s.bready) begin
          state_d   = IDLE;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      ar_done_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      ar_done_q <= ar_done_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign rd_addr = (st == RD1) ? m1.araddr : m0.araddr;
  assign wr_data = m1.wdata;

  always_comb begin
    // payload always muxed through; only valid/ready are gated by state
    s.araddr   = rd_addr;
    s.awaddr   = m1.awaddr;
    s.wdata    = wr_data;
    s.wstrb    = m1.wstrb;
    m0.rdata   = s.rdata;
    m0.rresp   = s.rresp;
    m1.rdata   = s.rdata;
    m1.rresp   = s.rresp;
    m1.bresp   = s.bresp;
    m0.bresp   = '0;
    s.arvalid  = 1'b0;
    s.rready   = 1'b0;
    s.awvalid  = 1'b0;
    s.wvalid   = 1'b0;
    s.bready   = 1'b0;
    m0.arready = 1'b0;
    m0.rvalid  = 1'b0;
    m0.awready = 1'b0;
    m0.wready  = 1'b0;
    m0.bvalid  = 1'b0;
    m1.arready = 1'b0;
    m1.rvalid  = 1'b0;
    m1.awready = 1'b0;
    m1.wready  = 1'b0;
    m1.bvalid  = 1'b0;
    case (st)
      RD0: begin
        s.arvalid  = m0.arvalid & ~ar_done_q;
        m0.arready = s.arready & ~ar_done_q;
        s.rready   = m0.rready;
        m0.rvalid  = s.rvalid;
      end
      RD1: begin
        s.arvalid  = m1.arvalid & ~ar_done_q;
        m1.arready = s.arready & ~ar_done_q;
        s.rready   = m1.rready;
        m1.rvalid  = s.rvalid;
      end
      WR1: begin
        s.awvalid  = m1.awvalid & ~aw_done_q;
        m1.awready = s.awready & ~aw_done_q;
        s.wvalid   = m1.wvalid & ~w_done_q;
        m1.wready  = s.wready & ~w_done_q;
        s.bready   = m1.bready;
        m1.bvalid  = s.bvalid;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: queue-driven master models, a slave model with
// configurable latencies, and a scoreboard of expected completions in order.
module tb_bus_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0 ();
  bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1 ();
  bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s ();

  bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .m0(m0), .m1(m1), .s(s)
  );

  typedef struct {logic [1:0] kind; logic [31:0] data; logic [1:0] resp;} exp_t;
  typedef struct {logic [31:0] addr; logic [31:0] data; logic [3:0] strb;} wr_t;

  exp_t        sb[$];
  logic [31:0] m0_aq[$], m1_aq[$];
  wr_t         m1_wq[$];
  wr_t         wcur;
  int checks = 0, errors = 0;

  int   r_lat = 0, aw_dly = 0, w_dly = 0;
  int   r_cnt = 0, aw_wait = 0, w_wait = 0;
  logic r_pend = 0, aw_got = 0, w_got = 0;
  logic [31:0] r_addr, aw_cap;
  int   n_saw = 0, n_sw = 0, n_sb = 0, cyc = 0, t_saw = 0, t_sw = 0;
  logic h_m0ar, h_m1ar, h_m1aw, h_m1w, h_sar, h_sr, h_saw, h_sw, h_sb, sv_aw, sv_w;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_f(input logic [31:0] a);
    return a ^ 32'h9234_5678;
  endfunction
  function automatic logic [1:0] rresp_f(input logic [31:0] a);
    return (a[3:0] == 4'hC) ? 2'b10 : 2'b00;
  endfunction
  function automatic logic [1:0] bresp_f(input logic [31:0] a);
    return a[2] ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [14:0] outs();
    return {s.arvalid, s.rready, s.awvalid, s.wvalid, s.bready,
            m0.arready, m0.rvalid, m0.awready, m0.wready, m0.bvalid,
            m1.arready, m1.rvalid, m1.awready, m1.wready, m1.bvalid};
  endfunction

  task automatic rd(input int m, input logic [31:0] a);
    exp_t e;
    if (m == 0) m0_aq.push_back(a); else m1_aq.push_back(a);
    e.kind = 2'(m); e.data = rd_f(a); e.resp = rresp_f(a);
    sb.push_back(e);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
    wr_t w;
    exp_t e;
    w.addr = a; w.data = d; w.strb = st;
    m1_wq.push_back(w);
    e.kind = 2'd2; e.data = 32'h0; e.resp = bresp_f(a);
    sb.push_back(e);
  endtask

  task automatic done(input logic [1:0] k, input logic [31:0] d, input logic [1:0] r);
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 64'(k) + 64'h100, 64'h0);
    end else begin
      e = sb.pop_front();
      chk("sb_kind", 64'(k), 64'(e.kind));
      if (k != 2'd2) chk("sb_data", 64'(d), 64'(e.data));
      chk("sb_resp", 64'(r), 64'(e.resp));
    end
  endtask

  // Sample at the falling edge: flags describe handshakes on the next rising edge.
  task automatic samp();
    @(negedge clk);
    cyc++;
    h_m0ar = m0.arvalid && m0.arready;
    h_m1ar = m1.arvalid && m1.arready;
    h_m1aw = m1.awvalid && m1.awready;
    h_m1w  = m1.wvalid && m1.wready;
    h_sar  = s.arvalid && s.arready;
    h_sr   = s.rvalid && s.rready;
    h_saw  = s.awvalid && s.awready;
    h_sw   = s.wvalid && s.wready;
    h_sb   = s.bvalid && s.bready;
    sv_aw  = s.awvalid;
    sv_w   = s.wvalid;
    if (s.awvalid || s.wvalid || s.bready)
      chk("wr_no_rd", {m0.arready, m1.arready, s.arvalid}, 0);
    if (m0.rvalid && m0.rready) done(2'd0, m0.rdata, m0.rresp);
    if (m1.rvalid && m1.rready) done(2'd1, m1.rdata, m1.rresp);
    if (m1.bvalid && m1.bready) done(2'd2, 32'h0, m1.bresp);
    if (h_sar) r_addr = s.araddr;
    if (h_saw) begin
      n_saw++; t_saw = cyc; aw_cap = s.awaddr;
      chk("s_awaddr", s.awaddr, wcur.addr);
    end
    if (h_sw) begin
      n_sw++; t_sw = cyc;
      chk("s_wdata", s.wdata, wcur.data);
      chk("s_wstrb", s.wstrb, wcur.strb);
    end
    if (h_sb) n_sb++;
  endtask

  // Drive new master/slave values just after the rising edge.
  task automatic upd();
    @(posedge clk);
    #1;
    if (h_m0ar) m0.arvalid = 1'b0;
    if (!m0.arvalid && m0_aq.size() > 0) begin m0.araddr = m0_aq.pop_front(); m0.arvalid = 1'b1; end
    if (h_m1ar) m1.arvalid = 1'b0;
    if (!m1.arvalid && m1_aq.size() > 0) begin m1.araddr = m1_aq.pop_front(); m1.arvalid = 1'b1; end
    if (h_m1aw) m1.awvalid = 1'b0;
    if (h_m1w)  m1.wvalid  = 1'b0;
    if (!m1.awvalid && !m1.wvalid && m1_wq.size() > 0) begin
      wcur = m1_wq.pop_front();
      m1.awaddr = wcur.addr; m1.wdata = wcur.data; m1.wstrb = wcur.strb;
      m1.awvalid = 1'b1; m1.wvalid = 1'b1;
    end
    if (rst) begin
      s.rvalid = 1'b0; s.awready = 1'b0; s.wready = 1'b0; s.bvalid = 1'b0;
      r_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0; aw_wait = 0; w_wait = 0;
    end else begin
      if (h_sr) s.rvalid = 1'b0;
      if (h_sar) begin r_pend = 1'b1; r_cnt = r_lat; end
      if (r_pend) begin
        if (r_cnt == 0) begin
          s.rvalid = 1'b1; s.rdata = rd_f(r_addr); s.rresp = rresp_f(r_addr); r_pend = 1'b0;
        end else r_cnt--;
      end
      if (h_saw) begin s.awready = 1'b0; aw_got = 1'b1; end
      else if (sv_aw && !aw_got && !s.awready) begin
        if (aw_wait >= aw_dly) s.awready = 1'b1; else aw_wait++;
      end
      if (h_sw) begin s.wready = 1'b0; w_got = 1'b1; end
      else if (sv_w && !w_got && !s.wready) begin
        if (w_wait >= w_dly) s.wready = 1'b1; else w_wait++;
      end
      if (h_sb) s.bvalid = 1'b0;
      if (aw_got && w_got) begin
        s.bvalid = 1'b1; s.bresp = bresp_f(aw_cap);
        aw_got = 1'b0; w_got = 1'b0; aw_wait = 0; w_wait = 0;
      end
    end
  endtask

  task automatic run(input string tag, input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin samp(); upd(); n++; end
    if (sb.size() > 0) begin
      chk({tag, "_timeout"}, 64'(sb.size()), 0);
      sb.delete();
    end
    samp();
    chk({tag, "_idle"}, outs(), 0);
    upd();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    m0.arvalid = 0; m0.araddr = 0; m0.rready = 1; m0.awvalid = 0; m0.awaddr = 0;
    m0.wvalid = 0; m0.wdata = 0; m0.wstrb = 0; m0.bready = 1;
    m1.arvalid = 0; m1.araddr = 0; m1.rready = 1; m1.awvalid = 0; m1.awaddr = 0;
    m1.wvalid = 0; m1.wdata = 0; m1.wstrb = 0; m1.bready = 1;
    s.arready = 1; s.rvalid = 0; s.rdata = 0; s.rresp = 0; s.awready = 0;
    s.wready = 0; s.bvalid = 0; s.bresp = 0;
    wcur = '{addr: 32'h0, data: 32'h0, strb: 4'h0};
    samp(); upd();
    samp(); chk("rst_outs", outs(), 0); upd();
    rst = 1'b0;

    // tie straight after reset: m0 first
    rd(0, 32'h0000_1000); rd(1, 32'h0000_200C);
    run("tie1", 30);

    // lone m0 read, grant latency and data
    rd(0, 32'h8000_0000);
    samp(); upd();
    samp(); chk("t1_sarv_n", s.arvalid, 0); upd();
    samp(); chk("t1_sarv_n1", s.arvalid, 1); chk("t1_araddr", s.araddr, 32'h8000_0000); upd();
    run("t1", 20);

    // m0 served last, so a tie now goes to m1 first
    rd(1, 32'h0000_3000); rd(0, 32'h0000_4004);
    run("tie2", 30);

    // write: slave takes w two cycles before aw
    aw_dly = 2; w_dly = 0; n_saw = 0; n_sw = 0; n_sb = 0;
    wr(32'h1001_0000, 32'hDEAD_BEEF, 4'hF);
    run("t3", 30);
    chk("t3_n_aw", n_saw, 1); chk("t3_n_w", n_sw, 1); chk("t3_n_b", n_sb, 1);
    chk("t3_w_lead", t_saw - t_sw, 2);

    // m1 read and write raised together: write first
    aw_dly = 0;
    wr(32'h2000_0044, 32'hCAFE_F00D, 4'h3);
    rd(1, 32'h2000_0040);
    run("t4", 40);

    // reset in RD1 after ar, before r
    r_lat = 4;
    rd(1, 32'h3000_0000);
    n = 0;
    do begin samp(); upd(); n++; end while (!h_sar && n < 10);
    chk("t5_ar_seen", h_sar, 1);
    rst = 1'b1;
    samp(); chk("t5_rst_outs", outs(), 0); upd();
    rst = 1'b0;
    sb.delete();
    samp(); chk("t5_post_outs", outs(), 0); upd();
    r_lat = 0;
    rd(0, 32'h8000_000C);
    run("t5", 20);

    // m0 stalls r for 5 cycles while m1 waits
    m0.rready = 1'b0;
    rd(0, 32'h4000_0008);
    samp(); upd(); samp(); upd();
    rd(1, 32'h5000_0000);
    n = 0;
    do begin samp(); upd(); n++; end while (!m0.rvalid && n < 10);
    chk("t6_rvalid_seen", m0.rvalid, 1);
    for (int i = 0; i < 5; i++) begin
      samp();
      chk("t6_hold_rvalid", m0.rvalid, 1);
      chk("t6_hold_rdata", m0.rdata, rd_f(32'h4000_0008));
      chk("t6_no_grant", {m1.arready, m1.rvalid, s.arvalid}, 0);
      upd();
    end
    m0.rready = 1'b1;
    run("t6", 30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width on all ports.
REQ-002 Parameter DATA_W, default 32, data width on all ports; strobe width is DATA_W/8.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 m0_ar{valid in 1, ready out 1, addr in ADDR_W}  master 0 (instruction fetch) read address.
REQ-006 m0_r{valid out 1, ready in 1, data out DATA_W, resp out 2}  master 0 read data.
REQ-007 m1_ar{valid in, ready out, addr in} and m1_r{valid out, ready in, data out, resp out}  master 1 (load/store) read channels, same widths as m0.
REQ-008 m1_aw{valid in 1, ready out 1, addr in ADDR_W}, m1_w{valid in 1, ready out 1, data in DATA_W, strb in DATA_W/8}, m1_b{valid out 1, ready in 1, resp out 2}  master 1 write channels.
REQ-009 s_ar*, s_r*, s_aw*, s_w*, s_b*  downstream slave port (device timer, memory, ...); mirrored directions, same widths.

Function
REQ-010 FSM states: IDLE, RD0 (m0 read), RD1 (m1 read), WR1 (m1 write); at most one outstanding transaction.
REQ-011 Pending requests in IDLE: R0 = m0_arvalid; R1 = m1_arvalid; W1 = m1_awvalid or m1_wvalid.
REQ-012 Inter-master choice round-robin: last_grant register (0 = m0, 1 = m1); if both masters pending, grant the master not in last_grant.
REQ-013 Within master 1, W1 beats R1 when both pending.
REQ-014 Grant is registered: request seen in IDLE at cycle N -> state is RDx/WR1 and downstream valid asserted at cycle N+1; last_grant updated on the same edge.
REQ-015 In IDLE: all *ready to masters, all *valid to masters, and all s_*valid/s_*ready = 0.
REQ-016 In RDx, two phases tracked by ar_done flag: before ar handshake, s_arvalid=mx_arvalid, s_araddr=mx_araddr, mx_arready=s_arready; after, s_arvalid=0.
REQ-017 In RDx, s_rready=mx_rready, mx_rvalid=s_rvalid, mx_rdata/mx_rresp=s_rdata/s_rresp; r handshake -> IDLE next cycle, ar_done cleared.
REQ-018 s_rvalid arriving in the same cycle as the ar handshake is forwarded unchanged.
REQ-019 In WR1, aw and w forwarded independently; aw_done/w_done flags set on their handshakes; either may complete first or together; each channel forced to valid=0 once done.
REQ-020 In WR1, s_bready=m1_bready, m1_bvalid=s_bvalid, m1_bresp=s_bresp; b handshake -> IDLE next cycle, aw_done/w_done cleared.
REQ-021 Non-granted master sees all its ready/valid outputs = 0; non-granted channels of the granted master also 0 (e.g. m1_arready=0 in WR1).
REQ-022 Data/addr/resp outputs are don't-care when their valid is 0; implementation drives them from the slave/master mux.
REQ-023 Master withdrawing valid before handshake (protocol violation) leaves arbiter in granted state until completion; no timeout.
REQ-024 Back-to-back: IDLE occupies exactly one cycle between transactions; minimum read occupancy 3 cycles (grant, ar+r, return).

Reset
REQ-025 rst=1 at any edge, including mid-transaction: state <= IDLE, last_grant <= 1 (m0 wins first tie), ar_done/aw_done/w_done <= 0.
REQ-026 During and after reset all valid/ready outputs are 0 until a new grant; in-flight downstream transaction is abandoned.

Verification
REQ-027 m0 read 0x8000_0000 alone, slave returns 0x1234_5678 one cycle after ar -> s_arvalid at N+1, m0_rvalid with data 0x1234_5678, OKAY; IDLE afterwards.
REQ-028 m0 and m1 reads asserted same cycle after reset -> m0 served first, m1 second; repeat -> order alternates m1, m0.
REQ-029 m1 write 0x1001_0000 data 0xDEAD_BEEF strb 0xF, slave accepts w two cycles before aw -> single s_w handshake, single s_aw handshake, m1_bvalid once, bresp 00.
REQ-030 m1 raises arvalid and awvalid together, m0 idle -> write completes before read; m1_arready stays 0 during WR1.
REQ-031 rst asserted in RD1 after ar handshake, before r -> next cycle all outputs 0, IDLE; subsequent m0 read completes normally.
REQ-032 Slave holds s_rvalid with m0_rready=0 for 5 cycles -> m0_rvalid/rdata stable, no other grant, state stays RD0.
